pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage ARM pipeline (IF, IF_Reg, ID, ID_Reg, EX, EX_Reg, MEM, MEM_Reg, WB).
- Combines three inputs: the ID data-hazard flag, the EX branch-taken flag and the MEM-stage memory handshake.
- Drives the freeze, flush and bubble inputs of the IF stage and of every pipeline register.
- Holds a memory-wait FSM with a timeout, plus saturating performance counters.

Parameters:
- MEM_TIMEOUT, 16, maximum number of cycles spent in MEM_WAIT before the error/halt trap (≥2).
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- CLK  in  1  pipeline clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-low.
- hazard  in  1  ID-stage source register matches a pending EX/MEM destination.
- branch_taken  in  1  EX stage resolved a taken branch this cycle.
- mem_req  in  1  MEM stage instruction is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- freeze_if  out  1  to IF.freeze and IF_Reg.freeze.
- flush_if  out  1  to IF_Reg.flush.
- flush_id  out  1  to ID_Reg flush; turns the ID_Reg contents into a NOP.
- bubble_id  out  1  ID_Reg loads a NOP instead of the ID output.
- freeze_all  out  1  freezes ID_Reg, EX_Reg and MEM_Reg; also ORed into freeze_if.
- halted  out  1  memory timeout trap is active.
- stall_cnt  out  CNT_W  count of cycles with freeze_if=1.
- flush_cnt  out  CNT_W  count of cycles with flush_if=1.

Behaviour:
- Reset (RST=0 at a rising edge):
  - state←RUN, wait_cnt←0, stall_cnt←0, flush_cnt←0.
  - All combinational outputs are forced to 0 while RST=0.
  - Reset is honoured from any state, including MEM_WAIT and ERROR.
- FSM states: RUN, MEM_WAIT, ERROR.
  - RUN→MEM_WAIT when mem_req=1 and mem_ready=0; wait_cnt←1.
  - MEM_WAIT→RUN when mem_ready=1 or mem_req=0; wait_cnt←0.
  - MEM_WAIT stays while mem_ready=0; wait_cnt increments.
  - MEM_WAIT→ERROR when wait_cnt=MEM_TIMEOUT-1 and mem_ready=0.
  - ERROR is sticky until reset.
- Combinational outputs, in priority order:
  1. ERROR: freeze_all=1, freeze_if=1, halted=1; flush_if, flush_id and bubble_id are 0.
  2. mem_req=1 and mem_ready=0, in RUN or MEM_WAIT: freeze_all=1, freeze_if=1. Branch and hazard are suppressed, because EX is held and re-presents them once the freeze releases.
  3. branch_taken=1: flush_if=1, flush_id=1, freeze_if=0, bubble_id=0. Hazard is ignored because the instruction in ID is being squashed.
  4. hazard=1: freeze_if=1, bubble_id=1.
  5. Otherwise all outputs are 0.
- Memory-wait timing:
  - The cycle mem_ready=1 arrives has freeze_all=0, so a 1-cycle memory access adds zero stalls.
  - A memory ready after N wait cycles freezes the pipeline for exactly N cycles.
- Counters:
  - stall_cnt increments on every edge where freeze_if=1; flush_cnt increments on every edge where flush_if=1.
  - Both saturate at 2^CNT_W-1 with no wrap, and neither counts during reset.
- Simultaneous events:
  - branch_taken together with hazard resolves to flush only.
  - branch_taken together with a memory wait resolves to freeze only; the flush occurs in the cycle after mem_ready.
- Timeout:
  - With MEM_TIMEOUT=16, a request never acknowledged gives 15 cycles in MEM_WAIT, then ERROR on the next edge.
  - freeze_all is 1 throughout.
- The FSM is registered; there is no combinational loop from outputs back to inputs.

Test Plan:
- Reset: hold RST=0 for 3 cycles with all inputs at 1 → all outputs 0, counters 0, state RUN after release.
- Hazard: hazard=1 for 2 cycles → freeze_if=1 and bubble_id=1 for exactly those 2 cycles; stall_cnt=2, flush_cnt=0.
- Branch with hazard: branch_taken=1 and hazard=1 for 1 cycle → flush_if=1, flush_id=1, freeze_if=0, bubble_id=0; flush_cnt=1, stall_cnt unchanged.
- Memory wait:
  - Stimulus: mem_req=1, mem_ready low for 3 cycles then high, with branch_taken=1 throughout.
  - Response: freeze_all=1 for 3 cycles, flush_if=0 during the wait, flush_if=1 in the ready cycle; stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready=0 forever → halted=1 from the 4th cycle after the request. It stays 1 even if mem_ready later goes to 1, and clears only after RST=0.
- Saturation: CNT_W=4, hazard=1 for 20 cycles → stall_cnt stops at 15. Mid-stall reset → stall_cnt=0 the next cycle.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush sequencer for the 5-stage ARM pipeline.
//
// Merges the ID data-hazard flag, the EX branch-taken flag and the MEM-stage
// memory handshake into freeze/flush/bubble controls for IF and the pipeline
// registers. A memory-wait FSM traps to a sticky ERROR state when an access
// is not acknowledged within MEM_TIMEOUT cycles. Two saturating counters
// record stall and flush cycles.
//
// Ports:
//   CLK          in   pipeline clock, rising edge
//   RST          in   synchronous active-low reset
//   hazard       in   ID source matches a pending EX/MEM destination
//   branch_taken in   EX resolved a taken branch this cycle
//   mem_req      in   MEM instruction is accessing data memory
//   mem_ready    in   data memory completes the access this cycle
//   freeze_if    out  IF.freeze / IF_Reg.freeze
//   flush_if     out  IF_Reg.flush
//   flush_id     out  ID_Reg flush (contents become a NOP)
//   bubble_id    out  ID_Reg loads a NOP instead of the ID output
//   freeze_all   out  freezes ID_Reg, EX_Reg and MEM_Reg
//   halted       out  memory timeout trap active
//   stall_cnt    out  cycles with freeze_if=1 (saturating)
//   flush_cnt    out  cycles with flush_if=1 (saturating)
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_if,
  output logic             flush_if,
  output logic             flush_id,
  output logic             bubble_id,
  output logic             freeze_all,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t            state_r;
  logic [WC_W-1:0]   wait_cnt_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;
  logic              mem_wait_s;

  // Memory access outstanding and not completed this cycle.
  assign mem_wait_s = mem_req & ~mem_ready;

  // Control outputs, highest priority first. They must be combinational so
  // that the cycle mem_ready arrives is already unfrozen (a 1-cycle access
  // costs no stall).
  always_comb begin
    freeze_if  = 1'b0;
    flush_if   = 1'b0;
    flush_id   = 1'b0;
    bubble_id  = 1'b0;
    freeze_all = 1'b0;
    halted     = 1'b0;
    if (!RST) begin
      freeze_if = 1'b0;
    end else if (state_r == ST_ERROR) begin
      freeze_all = 1'b1;
      freeze_if  = 1'b1;
      halted     = 1'b1;
    end else if (mem_wait_s) begin
      // EX is held, so branch/hazard will be re-presented after release.
      freeze_all = 1'b1;
      freeze_if  = 1'b1;
    end else if (branch_taken) begin
      // The instruction in ID is squashed, so a hazard on it is irrelevant.
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (hazard) begin
      freeze_if = 1'b1;
      bubble_id = 1'b1;
    end else begin
      freeze_if = 1'b0;
    end
  end

  // Memory-wait FSM with timeout counter; ERROR is left only via reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mem_wait_s) begin
            state_r    <= ST_MEM_WAIT;
            wait_cnt_r <= WC_W'(1);
          end else begin
            wait_cnt_r <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (!mem_wait_s) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= '0;
          end else if (wait_cnt_r == WC_LAST) begin
            state_r <= ST_ERROR;
          end else begin
            wait_cnt_r <= wait_cnt_r + WC_W'(1);
          end
        end
        ST_ERROR: begin
          state_r <= ST_ERROR;
        end
        default: begin
          state_r    <= ST_RUN;
          wait_cnt_r <= '0;
        end
      endcase
    end
  end

  // Saturating stall/flush performance counters.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (freeze_if && (stall_cnt_r != '1)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_if && (flush_cnt_r != '1)) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic CLK;
  logic RST;
  logic hazard;
  logic branch_taken;
  logic mem_req;
  logic mem_ready;

  // Default instance: MEM_TIMEOUT=16, CNT_W=16
  logic        freeze_if, flush_if, flush_id, bubble_id, freeze_all, halted;
  logic [15:0] stall_cnt, flush_cnt;
  // Short-timeout instance: MEM_TIMEOUT=4
  logic        t_freeze_if, t_flush_if, t_flush_id, t_bubble_id, t_freeze_all, t_halted;
  logic [15:0] t_stall_cnt, t_flush_cnt;
  // Narrow-counter instance: CNT_W=4
  logic        s_freeze_if, s_flush_if, s_flush_id, s_bubble_id, s_freeze_all, s_halted;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_if(freeze_if), .flush_if(flush_if), .flush_id(flush_id),
    .bubble_id(bubble_id), .freeze_all(freeze_all), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut_to (
    .CLK(CLK), .RST(RST), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_if(t_freeze_if), .flush_if(t_flush_if), .flush_id(t_flush_id),
    .bubble_id(t_bubble_id), .freeze_all(t_freeze_all), .halted(t_halted),
    .stall_cnt(t_stall_cnt), .flush_cnt(t_flush_cnt));

  pipe_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4)) dut_sat (
    .CLK(CLK), .RST(RST), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_if(s_freeze_if), .flush_if(s_flush_if), .flush_id(s_flush_id),
    .bubble_id(s_bubble_id), .freeze_all(s_freeze_all), .halted(s_halted),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Output vector order: {freeze_if, flush_if, flush_id, bubble_id, freeze_all, halted}
  function automatic logic [5:0] outs();
    return {freeze_if, flush_if, flush_id, bubble_id, freeze_all, halted};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic h, input logic b, input logic rq, input logic rd);
    hazard = h; branch_taken = b; mem_req = rq; mem_ready = rd;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    RST = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    set_in(1'b1, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({outs(), t_halted, t_freeze_all, s_freeze_if} !== 9'b0) begin
        errors++;
        $display("FAIL reset_outs cycle %0d: got %b expected 0", c, {outs(), t_halted, t_freeze_all, s_freeze_if});
      end
      tick();
    end
    checks++;
    if ({stall_cnt, flush_cnt} !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: got stall=%0d flush=%0d expected 0/0", stall_cnt, flush_cnt);
    end
    RST = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (outs() !== 6'b0) begin
      errors++;
      $display("FAIL reset_idle: got %b expected 000000", outs());
    end
    // 1-cycle memory access from RUN: no freeze
    set_in(1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    checks++;
    if (outs() !== 6'b0) begin
      errors++;
      $display("FAIL reset_run_state: got %b expected 000000", outs());
    end
    tick();
    checks++;
    if ({stall_cnt, flush_cnt} !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt_after: got stall=%0d flush=%0d expected 0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_hazard();
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (outs() !== 6'b100100) begin
        errors++;
        $display("FAIL hazard_outs cycle %0d: got %b expected 100100", c, outs());
      end
      tick();
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (outs() !== 6'b0) begin
      errors++;
      $display("FAIL hazard_release: got %b expected 000000", outs());
    end
    tick();
    checks++;
    if (stall_cnt !== 16'd2 || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL hazard_cnt: got stall=%0d flush=%0d expected 2/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_branch_hazard();
    // Continues from test_hazard: stall_cnt=2
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (outs() !== 6'b011000) begin
      errors++;
      $display("FAIL branch_hazard_outs: got %b expected 011000", outs());
    end
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (stall_cnt !== 16'd2 || flush_cnt !== 16'd1) begin
      errors++;
      $display("FAIL branch_hazard_cnt: got stall=%0d flush=%0d expected 2/1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    set_in(1'b0, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (outs() !== 6'b100010) begin
        errors++;
        $display("FAIL mem_wait_outs cycle %0d: got %b expected 100010", c, outs());
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (outs() !== 6'b011000) begin
      errors++;
      $display("FAIL mem_ready_cycle: got %b expected 011000", outs());
    end
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (stall_cnt !== 16'd3 || flush_cnt !== 16'd1 || outs() !== 6'b0) begin
      errors++;
      $display("FAIL mem_wait_cnt: got stall=%0d flush=%0d outs=%b expected 3/1/000000", stall_cnt, flush_cnt, outs());
    end
    // Short-timeout instance survived a 3-cycle wait without trapping
    checks++;
    if (t_halted !== 1'b0) begin
      errors++;
      $display("FAIL mem_wait_no_trap: got halted=%b expected 0", t_halted);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    set_in(1'b0, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 18; c++) begin
      #1;
      checks++;
      if (t_halted !== (c >= 4) || t_freeze_all !== 1'b1 || t_flush_if !== 1'b0) begin
        errors++;
        $display("FAIL timeout4 cycle %0d: got halted=%b freeze_all=%b flush_if=%b expected %0d/1/0", c, t_halted, t_freeze_all, t_flush_if, (c >= 4));
      end
      checks++;
      if (halted !== (c >= 16) || freeze_all !== 1'b1) begin
        errors++;
        $display("FAIL timeout16 cycle %0d: got halted=%b freeze_all=%b expected %0d/1", c, halted, freeze_all, (c >= 16));
      end
      tick();
    end
    // Late ready does not release the trap
    mem_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({t_freeze_if, t_flush_if, t_flush_id, t_bubble_id, t_freeze_all, t_halted} !== 6'b100011) begin
        errors++;
        $display("FAIL timeout_sticky cycle %0d: got %b expected 100011", c,
                 {t_freeze_if, t_flush_if, t_flush_id, t_bubble_id, t_freeze_all, t_halted});
      end
      tick();
    end
    RST = 1'b0;
    #1;
    checks++;
    if (t_halted !== 1'b0 || t_freeze_all !== 1'b0) begin
      errors++;
      $display("FAIL timeout_rst_comb: got halted=%b freeze_all=%b expected 0/0", t_halted, t_freeze_all);
    end
    tick();
    RST = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (t_halted !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL timeout_cleared: got halted4=%b halted16=%b expected 0/0", t_halted, halted);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (s_stall_cnt !== ((c + 1 > 15) ? 4'd15 : 4'(c + 1))) begin
        errors++;
        $display("FAIL sat_cnt cycle %0d: got %0d expected %0d", c, s_stall_cnt, ((c + 1 > 15) ? 15 : c + 1));
      end
    end
    checks++;
    if (stall_cnt !== 16'd20) begin
      errors++;
      $display("FAIL sat_wide_cnt: got %0d expected 20", stall_cnt);
    end
    // Mid-stall reset
    RST = 1'b0;
    #1;
    checks++;
    if (s_freeze_if !== 1'b0) begin
      errors++;
      $display("FAIL sat_rst_freeze: got %b expected 0", s_freeze_if);
    end
    tick();
    checks++;
    if (s_stall_cnt !== 4'd0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL sat_rst_cnt: got %0d/%0d expected 0/0", s_stall_cnt, stall_cnt);
    end
    RST = 1'b1;
    tick();
    checks++;
    if (s_stall_cnt !== 4'd1) begin
      errors++;
      $display("FAIL sat_restart: got %0d expected 1", s_stall_cnt);
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    RST = 1'b0;
    hazard = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    #1;
    test_reset();
    test_hazard();
    test_branch_hazard();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
